// File: rtl/lstm_pkg.sv
// rtl/lstm_pkg.sv - shared types and helpers for the LSTM sequence scheduler
// Contents: lstm_state_e (scheduler FSM states), lstm_clog2 (width helper, minimum 1).
package lstm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        ISSUE,
        WAIT,
        SETTLE,
        DRAIN
    } lstm_state_e;

    // Ceiling log2 used for index/counter widths; never returns less than 1
    // so a single-entry dimension still gets a legal one-bit vector.
    function automatic int lstm_clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/lstm_seq_sched_if.sv
// rtl/lstm_seq_sched_if.sv - sample/network/neuron-word bundle of the LSTM sequence scheduler
// Groups: in_* sample stream, net_* network control/result, out_* serialized neuron words,
// step and err_timeout status. Modport slave = scheduler side, master = environment side.
interface lstm_seq_sched_if import lstm_pkg::*; #(
    parameter int INPUT_SZ  = 2,
    parameter int HIDDEN_SZ = 8,
    parameter int QN        = 6,
    parameter int QM        = 11,
    parameter int SEQ_LEN   = 8
);
    localparam int BITWIDTH = QN + QM + 1;
    localparam int IN_W     = BITWIDTH * INPUT_SZ;
    localparam int H_W      = BITWIDTH * HIDDEN_SZ;
    localparam int IDX_W    = lstm_clog2(HIDDEN_SZ);
    localparam int STEP_W   = lstm_clog2(SEQ_LEN);

    logic                in_valid;
    logic                in_ready;
    logic [IN_W-1:0]     in_data;
    logic [IN_W-1:0]     net_x;
    logic                net_reset;
    logic                net_newSample;
    logic                net_dataReady;
    logic [H_W-1:0]      net_h;
    logic                out_valid;
    logic                out_ready;
    logic [BITWIDTH-1:0] out_data;
    logic [IDX_W-1:0]    out_idx;
    logic                out_last;
    logic [STEP_W-1:0]   step;
    logic                err_timeout;

    modport slave (
        input  in_valid, in_data, net_dataReady, net_h, out_ready,
        output in_ready, net_x, net_reset, net_newSample,
               out_valid, out_data, out_idx, out_last, step, err_timeout
    );

    modport master (
        output in_valid, in_data, net_dataReady, net_h, out_ready,
        input  in_ready, net_x, net_reset, net_newSample,
               out_valid, out_data, out_idx, out_last, step, err_timeout
    );

endinterface

// File: rtl/lstm_h_serializer.sv
// rtl/lstm_h_serializer.sv - captures the hidden vector and emits it one neuron word at a time
// Ports: clock/reset (async active-low), capture (load pulse), h_in (hidden vector),
// out_valid/out_ready/out_data/out_idx (word handshake), done (last word accepted, combinational).
module lstm_h_serializer import lstm_pkg::*; #(
    parameter int HIDDEN_SZ = 8,
    parameter int BITWIDTH  = 18,
    parameter int IDX_W     = lstm_clog2(HIDDEN_SZ)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          capture,
    input  logic [BITWIDTH*HIDDEN_SZ-1:0] h_in,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [BITWIDTH-1:0]           out_data,
    output logic [IDX_W-1:0]              out_idx,
    output logic                          done
);
    localparam int H_W = BITWIDTH * HIDDEN_SZ;

    logic [H_W-1:0]   h_q, h_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             last_word;

    assign last_word = (idx_q == IDX_W'(HIDDEN_SZ - 1));

    always_comb begin
        h_d     = h_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        done    = 1'b0;
        if (capture) begin
            h_d     = h_in;
            idx_d   = '0;
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            if (last_word) begin
                // Park the index at 0 so a stale index never lingers after the burst.
                valid_d = 1'b0;
                idx_d   = '0;
                done    = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            h_q     <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            h_q     <= h_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    // Word is selected from registered state only, so it is stable during back-pressure.
    assign out_data  = h_q[idx_q*BITWIDTH +: BITWIDTH];
    assign out_idx   = idx_q;
    assign out_valid = valid_q;

endmodule

// File: rtl/lstm_seq_sched.sv
// rtl/lstm_seq_sched.sv - per-timestep scheduler driving an LSTM core and serializing its hidden vector
// Ports: clock, reset (async active-low), bus (lstm_seq_sched_if.slave: sample in, network
// control/result, neuron word out, step, err_timeout).
// Optional watchdog on WAIT enabled by defining LSTM_SCHED_TIMEOUT_EN; otherwise err_timeout is 0.
module lstm_seq_sched import lstm_pkg::*; #(
    parameter int INPUT_SZ       = 2,
    parameter int HIDDEN_SZ      = 8,
    parameter int QN             = 6,
    parameter int QM             = 11,
    parameter int SEQ_LEN        = 8,
    parameter int CLR_CYCLES     = 4,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clock,
    input  logic               reset,
    lstm_seq_sched_if.slave    bus
);
    localparam int BITWIDTH = QN + QM + 1;
    localparam int IN_W     = BITWIDTH * INPUT_SZ;
    localparam int IDX_W    = lstm_clog2(HIDDEN_SZ);
    localparam int STEP_W   = lstm_clog2(SEQ_LEN);
    localparam int CNT_W    = 16;

    lstm_state_e       state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IN_W-1:0]   x_q, x_d;
    logic              net_reset_q, net_reset_d;
    logic              new_sample_q, new_sample_d;
    logic              dr_prev_q, dr_prev_d;
    logic              edge_seen_q, edge_seen_d;
    logic              dr_rise;
    logic              capture;
    logic              ser_done;
    logic              ser_valid;
    logic [IDX_W-1:0]  ser_idx;

`ifdef LSTM_SCHED_TIMEOUT_EN
    localparam int WD_W = lstm_clog2(TIMEOUT_CYCLES) + 1;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
`endif

    assign dr_rise = bus.net_dataReady && !dr_prev_q;

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        edge_seen_d = edge_seen_q;
        dr_prev_d   = bus.net_dataReady;
        capture     = 1'b0;
`ifdef LSTM_SCHED_TIMEOUT_EN
        wd_d        = wd_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    x_d         = bus.in_data;
                    cnt_d       = '0;
                    edge_seen_d = 1'b0;
                    // Only the first timestep of a sequence clears the network state.
                    state_d     = (step_q == '0) ? CLR : ISSUE;
                end
            end
            CLR: begin
                if (cnt_q == CNT_W'(CLR_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ISSUE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ISSUE: begin
                // A fast network may complete while the start pulse is still high;
                // remember that edge so WAIT does not miss it.
                edge_seen_d = dr_rise;
                state_d     = WAIT;
`ifdef LSTM_SCHED_TIMEOUT_EN
                wd_d        = '0;
`endif
            end
            WAIT: begin
                if (dr_rise || edge_seen_q) begin
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
`ifdef LSTM_SCHED_TIMEOUT_EN
                else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    step_d  = '0;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    capture = 1'b1;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (ser_done) begin
                    step_d  = (step_q == STEP_W'(SEQ_LEN - 1)) ? '0 : step_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        net_reset_d  = (state_d == CLR);
        new_sample_d = (state_d == ISSUE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            step_q       <= '0;
            cnt_q        <= '0;
            x_q          <= '0;
            net_reset_q  <= 1'b0;
            new_sample_q <= 1'b0;
            dr_prev_q    <= 1'b0;
            edge_seen_q  <= 1'b0;
`ifdef LSTM_SCHED_TIMEOUT_EN
            wd_q         <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            cnt_q        <= cnt_d;
            x_q          <= x_d;
            net_reset_q  <= net_reset_d;
            new_sample_q <= new_sample_d;
            dr_prev_q    <= dr_prev_d;
            edge_seen_q  <= edge_seen_d;
`ifdef LSTM_SCHED_TIMEOUT_EN
            wd_q         <= wd_d;
            err_q        <= err_d;
`endif
        end
    end

    lstm_h_serializer #(
        .HIDDEN_SZ (HIDDEN_SZ),
        .BITWIDTH  (BITWIDTH),
        .IDX_W     (IDX_W)
    ) u_ser (
        .clock     (clock),
        .reset     (reset),
        .capture   (capture),
        .h_in      (bus.net_h),
        .out_ready (bus.out_ready),
        .out_valid (ser_valid),
        .out_data  (bus.out_data),
        .out_idx   (ser_idx),
        .done      (ser_done)
    );

    assign bus.in_ready      = (state_q == IDLE);
    assign bus.net_x         = x_q;
    assign bus.net_reset     = net_reset_q;
    assign bus.net_newSample = new_sample_q;
    assign bus.out_valid     = ser_valid;
    assign bus.out_idx       = ser_idx;
    assign bus.out_last      = ser_valid && (ser_idx == IDX_W'(HIDDEN_SZ - 1))
                               && (step_q == STEP_W'(SEQ_LEN - 1));
    assign bus.step          = step_q;
`ifdef LSTM_SCHED_TIMEOUT_EN
    assign bus.err_timeout   = err_q;
`else
    assign bus.err_timeout   = 1'b0;
`endif

endmodule
